// File: rtl/drive_pkg.sv
// Shared encodings and helpers for the manual-transmission drive controller.
package drive_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned MOTION_W = 4;
  localparam int unsigned LIGHT_W  = 3;

  typedef logic [STATE_W-1:0]  drive_state_t;
  typedef logic [MOTION_W-1:0] motion_t;

  localparam drive_state_t NS = 2'b00;
  localparam drive_state_t ST = 2'b01;
  localparam drive_state_t MV = 2'b10;

  localparam int unsigned MV_LEFT  = 0;
  localparam int unsigned MV_RIGHT = 1;
  localparam int unsigned MV_FWD   = 2;
  localparam int unsigned MV_BACK  = 3;

  localparam logic [1:0] UART_MODE = 2'b10;

  // Pedal-driven transition while powered and not stalled; 11 falls back to NS.
  function automatic drive_state_t next_state(input drive_state_t st, input logic throttle,
                                              input logic clutch, input logic brake);
    drive_state_t nxt;
    nxt = st;
    case (st)
      NS: if (throttle && clutch && !brake) nxt = ST;
      ST: begin
        if (brake) nxt = NS;
        else if (throttle && !clutch) nxt = MV;
      end
      MV: begin
        if (brake) nxt = NS;
        else if (clutch) nxt = ST;
      end
      default: nxt = NS;
    endcase
    return nxt;
  endfunction

  // Motion command for a given next state; both turn switches cancel each other.
  function automatic motion_t motion_cmd(input drive_state_t st, input logic rgs,
                                         input logic left, input logic right);
    motion_t m;
    m = '0;
    if (st == MV) begin
      m[MV_FWD]   = ~rgs;
      m[MV_BACK]  = rgs;
      m[MV_LEFT]  = left & ~right;
      m[MV_RIGHT] = right & ~left;
    end
    return m;
  endfunction

  function automatic logic [LIGHT_W-1:0] state_onehot(input drive_state_t st);
    logic [LIGHT_W-1:0] l;
    l = '0;
    case (st)
      NS:      l = 3'b001;
      ST:      l = 3'b010;
      MV:      l = 3'b100;
      default: l = 3'b000;
    endcase
    return l;
  endfunction

  function automatic logic [7:0] uart_byte(input logic destroy, input logic place,
                                           input motion_t ms);
    return {UART_MODE, destroy, place, ms};
  endfunction

endpackage

// File: rtl/manual_drive_ctrl_if.sv
// Switch inputs and indicator/command outputs of the drive controller.
interface manual_drive_ctrl_if;
  import drive_pkg::*;

  logic                power_on;
  logic                power_off;
  logic                throttle;
  logic                clutch;
  logic                brake;
  logic                rgs;
  logic                left;
  logic                right;
  logic                power;
  drive_state_t        state;
  motion_t             moving_state;
  logic                power_light;
  logic [LIGHT_W-1:0]  state_light;
  logic                turn_left_light;
  logic                turn_right_light;
  motion_t             moving_light;

  modport master (
    output power_on, power_off, throttle, clutch, brake, rgs, left, right,
    input  power, state, moving_state, power_light, state_light,
           turn_left_light, turn_right_light, moving_light
  );

  modport slave (
    input  power_on, power_off, throttle, clutch, brake, rgs, left, right,
    output power, state, moving_state, power_light, state_light,
           turn_left_light, turn_right_light, moving_light
  );
endinterface

// File: rtl/power_hold_timer.sv
// Counts consecutive cycles of a held button; pulses done on the last required cycle.
module power_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic btn,
  input  logic enable,
  output logic done_c
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign done_c = enable & btn & (cnt == CNT_W'(HOLD_CYCLES - 1));

  // Any gap in the hold discards accumulated credit.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || !btn || done_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission drive controller: power latch, drive state and motion command.
module manual_drive_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic                sys_clk,
  input  logic                rst,
  manual_drive_ctrl_if.slave  bus
);

  logic         power;
  drive_state_t state;
  motion_t      moving_state;
  logic         rgs_q;
  logic         hold_done_c;
  logic         stall_c;
  drive_state_t state_nxt_c;

  power_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .sys_clk (sys_clk),
    .rst     (rst),
    .btn     (bus.power_on),
    .enable  (~power),
    .done_c  (hold_done_c)
  );

  // Engine stalls on throttle-without-clutch at rest, or gear change while moving unclutched.
  assign stall_c = ~bus.clutch &
                   (((state == NS) & bus.throttle) | ((state == MV) & (bus.rgs != rgs_q)));

  assign state_nxt_c = next_state(state, bus.throttle, bus.clutch, bus.brake);

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      power        <= 1'b0;
      state        <= NS;
      moving_state <= '0;
      rgs_q        <= 1'b0;
    end else begin
      rgs_q <= bus.rgs;
      if (power) begin
        if (bus.power_off || stall_c) begin
          power        <= 1'b0;
          state        <= NS;
          moving_state <= '0;
        end else begin
          state        <= state_nxt_c;
          moving_state <= motion_cmd(state_nxt_c, bus.rgs, bus.left, bus.right);
        end
      end else begin
        state        <= NS;
        moving_state <= '0;
        if (hold_done_c) power <= 1'b1;
      end
    end
  end

  assign bus.power            = power;
  assign bus.state            = state;
  assign bus.moving_state     = moving_state;
  assign bus.power_light      = power;
  assign bus.state_light      = power ? state_onehot(state) : '0;
  assign bus.turn_left_light  = power & bus.left;
  assign bus.turn_right_light = power & bus.right;
  assign bus.moving_light     = moving_state;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed and randomized checks of manual_drive_ctrl against a behavioural car model.
module tb_manual_drive_ctrl;

  localparam int unsigned HOLD = 10;

  logic sys_clk;
  logic rst;
  int   checks;
  int   failures;

  manual_drive_ctrl_if bus ();

  manual_drive_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Behavioural model: 0 = not-starting, 1 = starting, 2 = moving.
  bit m_power;
  int m_state;
  int m_motion;
  int m_held;
  bit m_prev_gear;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit po, input bit pf, input bit thr, input bit clu,
                        input bit brk, input bit gear, input bit l, input bit r);
    bus.power_on  = po;
    bus.power_off = pf;
    bus.throttle  = thr;
    bus.clutch    = clu;
    bus.brake     = brk;
    bus.rgs       = gear;
    bus.left      = l;
    bus.right     = r;
  endtask

  task automatic model_clock();
    bit gear_changed;
    bit stall;
    int nxt;
    if (!rst) begin
      m_power = 0; m_state = 0; m_motion = 0; m_held = 0; m_prev_gear = 0;
      return;
    end
    gear_changed = (bus.rgs != m_prev_gear);
    m_prev_gear  = bus.rgs;
    if (!m_power) begin
      m_state  = 0;
      m_motion = 0;
      if (bus.power_on) begin
        m_held++;
        if (m_held == HOLD) begin
          m_power = 1;
          m_held  = 0;
        end
      end else begin
        m_held = 0;
      end
      return;
    end
    m_held = 0;
    stall = !bus.clutch && ((m_state == 0 && bus.throttle) || (m_state == 2 && gear_changed));
    if (bus.power_off || stall) begin
      m_power = 0; m_state = 0; m_motion = 0;
      return;
    end
    nxt = m_state;
    if (m_state == 0 && bus.throttle && bus.clutch && !bus.brake) nxt = 1;
    else if (m_state == 1 && bus.brake) nxt = 0;
    else if (m_state == 1 && bus.throttle && !bus.clutch) nxt = 2;
    else if (m_state == 2 && bus.brake) nxt = 0;
    else if (m_state == 2 && bus.clutch) nxt = 1;
    m_state  = nxt;
    m_motion = 0;
    if (m_state == 2) begin
      m_motion += bus.rgs ? 8 : 4;
      if (bus.left && !bus.right) m_motion += 1;
      if (bus.right && !bus.left) m_motion += 2;
    end
  endtask

  task automatic check_all();
    check_eq("power",       32'(bus.power),            32'(m_power));
    check_eq("state",       32'(bus.state),            32'(m_state));
    check_eq("moving",      32'(bus.moving_state),     32'(m_motion));
    check_eq("power_light", 32'(bus.power_light),      32'(m_power));
    check_eq("state_light", 32'(bus.state_light),      m_power ? (32'd1 << m_state) : 32'd0);
    check_eq("turn_l",      32'(bus.turn_left_light),  32'(m_power & bus.left));
    check_eq("turn_r",      32'(bus.turn_right_light), 32'(m_power & bus.right));
    check_eq("moving_light",32'(bus.moving_light),     32'(m_motion));
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic power_up();
    set_in(1, 0, 0, 0, 0, bus.rgs, 0, 0);
    repeat (HOLD) step();
    bus.power_on = 0;
  endtask

  task automatic drive_to_mv();
    set_in(0, 0, 1, 1, 0, bus.rgs, 0, 0);
    step();
    bus.clutch = 0;
    step();
    bus.throttle = 0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_eq("reset_power", 32'(bus.power), 32'd0);
    check_eq("reset_light", 32'(bus.state_light), 32'd0);
    rst = 1;

    // Nine-cycle hold must not power up.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (HOLD - 1) step();
    bus.power_on = 0;
    step();
    check_eq("short_hold", 32'(bus.power), 32'd0);

    power_up();
    check_eq("pwr_up", 32'(bus.power), 32'd1);
    check_eq("pwr_up_light", 32'(bus.state_light), 32'd1);

    set_in(0, 0, 1, 1, 0, 0, 0, 0);
    step();
    check_eq("start", 32'(bus.state), 32'd1);
    bus.clutch = 0;
    step();
    check_eq("move_fwd", 32'(bus.moving_state), 32'h4);
    bus.left = 1;
    step();
    check_eq("move_left", 32'(bus.moving_state), 32'h5);
    bus.right = 1;
    step();
    check_eq("move_both", 32'(bus.moving_state), 32'h4);

    set_in(0, 0, 1, 0, 1, 0, 0, 0);
    step();
    check_eq("brake_state", 32'(bus.state), 32'd0);
    check_eq("brake_motion", 32'(bus.moving_state), 32'd0);

    drive_to_mv();
    bus.clutch = 1;
    step();
    check_eq("clutch_st", 32'(bus.state), 32'd1);
    bus.rgs = 1;
    step();
    check_eq("gear_clutched", 32'(bus.power), 32'd1);
    bus.clutch = 0; bus.throttle = 1;
    step();
    check_eq("move_back", 32'(bus.moving_state), 32'h8);
    bus.throttle = 0; bus.rgs = 0;
    step();
    check_eq("gear_stall", 32'(bus.power), 32'd0);
    check_eq("gear_stall_mv", 32'(bus.moving_state), 32'd0);

    power_up();
    set_in(0, 0, 1, 0, 0, 0, 0, 0);
    step();
    check_eq("ns_stall", 32'(bus.power), 32'd0);
    check_eq("ns_stall_light", 32'(bus.state_light), 32'd0);

    power_up();
    drive_to_mv();
    set_in(1, 1, 1, 0, 0, 0, 1, 0);
    step();
    check_eq("poff_power", 32'(bus.power), 32'd0);
    check_eq("poff_tl", 32'(bus.turn_left_light), 32'd0);

    power_up();
    drive_to_mv();
    rst = 0;
    step();
    check_eq("rst_mv", 32'(bus.moving_state), 32'd0);
    rst = 1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step();
    rst = 0;
    step();
    rst = 1;
    repeat (HOLD - 1) step();
    check_eq("rst_hold", 32'(bus.power), 32'd0);
    step();
    check_eq("rst_hold_full", 32'(bus.power), 32'd1);

    // Randomized run with inputs biased so the car actually powers up and drives.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) != 0);
      bus.power_on  = ($urandom_range(0, 9) != 0);
      bus.power_off = ($urandom_range(0, 59) == 0);
      bus.throttle  = 1'($urandom);
      bus.clutch    = 1'($urandom);
      bus.brake     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.rgs = ~bus.rgs;
      bus.left      = 1'($urandom);
      bus.right     = 1'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/manual_drive_ctrl.md
Name: manual_drive_ctrl

Overview:
- Manual-transmission driving controller for the simulated car.
- Tracks the power, the drive state (not-starting / starting / moving) and the 4-bit motion command from the pedal, gear and turn switches.
- The parent packs the motion command into the UART byte {2'b10, destroy, place, moving_state} sent to the simulator.
- Also drives the power, state, turn and motion indicator lights.

Parameters:
- HOLD_CYCLES, 100_000_000: consecutive cycles power_on must be held to power up (1 s at 100 MHz); the bench overrides it to a small value.

Ports:
- sys_clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous active-low reset
- power_on  in  1  power-on button, level
- power_off  in  1  power-off button, level
- throttle  in  1  throttle pedal
- clutch  in  1  clutch pedal
- brake  in  1  brake pedal
- rgs  in  1  reverse gear switch (1 = reverse)
- left  in  1  turn-left switch
- right  in  1  turn-right switch
- power  out  1  registered power flag
- state  out  2  registered drive state
- moving_state  out  4  registered motion command: [0] left, [1] right, [2] forward, [3] backward
- power_light  out  1  equals power
- state_light  out  3  one-hot: [0] not-starting, [1] starting, [2] moving; 000 when powered off
- turn_left_light  out  1  power & left
- turn_right_light  out  1  power & right
- moving_light  out  4  equals moving_state

Behaviour:
- All state updates on the rising edge of sys_clk.
- Registered outputs have 1-cycle latency from inputs.
- Reset (rst=0, sampled at clock edge): power=0, state=NS (00), moving_state=0000, hold counter=0. Every output reads 0.
- State encoding: NS=00 (not-starting), ST=01 (starting), MV=10 (moving); 11 is illegal and goes to NS.
- Hold counter:
  - Counts while power=0 and power_on=1; clears when power_on=0.
  - When the count reaches HOLD_CYCLES-1 with power_on still 1: power<=1, state<=NS, counter clears.
  - Releasing power_on earlier aborts, with no partial credit.
- Priority each cycle, highest first: reset, power_off, stall events, brake, normal transitions.
- power_off=1 while powered: power<=0, state<=NS, moving_state<=0 next cycle. This overrides everything, including a simultaneous power_on.
- While power=0: state stays NS, moving_state stays 0, and the pedal/gear/turn inputs are ignored.
- Stall (power<=0, state<=NS):
  - In NS: throttle=1 and clutch=0.
  - In MV: rgs changes value (versus the previous-cycle registered copy) while clutch=0.
- Transitions with power=1:
  - NS, throttle=1, clutch=1, brake=0 -> ST.
  - ST, brake=1 -> NS.
  - ST, throttle=1, clutch=0, brake=0 -> MV.
  - MV, brake=1 -> NS (brake wins over throttle).
  - MV, clutch=1 -> ST.
  - Any other combination holds the state.
- moving_state:
  - Recomputed every cycle from the next state.
  - If the next state is MV: bit2 = ~rgs, bit3 = rgs, bit0 = left & ~right, bit1 = right & ~left.
  - Otherwise 0000. Both turn switches on means no turn.
- Gear change with clutch=1 in MV: the state goes to ST via the clutch rule and power stays on.
- Reset asserted mid-hold or while moving: immediate return to the reset values.

Decomposition:
- Shared package drive_pkg:
  - State localparams NS/ST/MV.
  - Motion bit indices MV_LEFT=0, MV_RIGHT=1, MV_FWD=2, MV_BACK=3.
  - UART mode prefix 2'b10.
- One sub-module, power_hold_timer:
  - Parameter HOLD_CYCLES.
  - Inputs sys_clk, rst, btn, enable.
  - Output one-cycle done pulse.

Test Plan:
- Power-up: HOLD_CYCLES=10, power_on high for 10 cycles -> power=1, state=00, state_light=001. Holding only 9 cycles, then releasing -> power stays 0.
- Start and drive: clutch=1 + throttle=1 -> state=01. Then clutch=0, throttle=1 -> state=10 and moving_state=0100. Add left=1 -> 0101; set left=right=1 -> 0100.
- Stall: in NS, throttle=1, clutch=0 -> power=0, state_light=000. In MV, toggle rgs with clutch=0 -> power=0, moving_state=0000.
- Brake/clutch: in MV, brake=1 -> state=00, moving_state=0000. In MV, clutch=1 -> state=01; then toggling rgs -> power stays 1, and the next MV gives moving_state=1000.
- Power-off priority: in MV, power_off=1 together with throttle=1 -> next cycle power=0, state=00, all lights 0.
- Reset mid-operation: rst=0 while in MV, or mid-hold at count 5 -> all outputs 0. A new power-up needs the full HOLD_CYCLES.
